aurora_link_supervisor: RTL and testbench

Init-clock-domain controller that sequences Aurora core bring-up and supervises the link afterwards. It orders gt_reset and reset release, waits for a stable channel_up, and retries on timeout. It re-initialises the core on link loss and latches a fail state when retries are exhausted. It sits between board reset/software control and the Aurora core's reset and gt_reset pins, and provides link_ready to the TX/RX reset logic.

---
 rtl/aurora_link_supervisor.sv | 216 +++++++++++++++++++++
 tb/tb_aurora_link_supervisor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_supervisor.sv
// Aurora link supervisor: sequences gt_reset/reset bring-up, waits for a
// stable channel_up, retries on timeout, re-inits on loss, latches fail.
//
// Ports:
//   init_clk     free-running init clock (all registers)
//   RST          synchronous, active-high reset
//   channel_up   Aurora channel_up (async, synchronised here)
//   hard_err     Aurora hard_err (async, used only with the macro below)
//   retrain      one-cycle pulse forcing full re-initialisation
//   reset_Aurora Aurora reset pin
//   gt_reset     Aurora gt_reset pin
//   link_ready   high only in UP
//   link_fail    high only in FAIL
//   state_o      0 GT_RST 1 CORE_RST 2 WAIT_UP 3 STABLE 4 UP 5 FAIL
//   retry_cnt    timeouts since the last successful link-up
//   down_cnt     saturating count of link losses from UP
//
// Build option: define AURORA_SUP_HARD_ERR_EN to re-init on hard_err in
// STABLE/UP. Without it hard_err is ignored.

module aurora_link_supervisor #(
  parameter int unsigned GT_RESET_CYCLES   = 16,
  parameter int unsigned RESET_HOLD_CYCLES = 8,
  parameter int unsigned UP_TIMEOUT_CYCLES = 65535,
  parameter int unsigned STABLE_CYCLES     = 16,
  parameter int unsigned MAX_RETRIES       = 3,
  parameter int unsigned CNT_W             = 20
) (
  input  logic       init_clk,
  input  logic       RST,
  input  logic       channel_up,
  input  logic       hard_err,
  input  logic       retrain,
  output logic       reset_Aurora,
  output logic       gt_reset,
  output logic       link_ready,
  output logic       link_fail,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt,
  output logic [7:0] down_cnt
);

  typedef enum logic [2:0] {
    S_GT_RST   = 3'd0,
    S_CORE_RST = 3'd1,
    S_WAIT_UP  = 3'd2,
    S_STABLE   = 3'd3,
    S_UP       = 3'd4,
    S_FAIL     = 3'd5
  } state_e;

  // Last count value of each timed phase: the phase lasts N cycles.
  localparam logic [CNT_W-1:0] GT_LAST =
    CNT_W'(GT_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] UP_LAST =
    CNT_W'(UP_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX =
    CNT_W'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       down_q, down_d;
  logic             rst_aur_q, gt_rst_q;
  logic             ready_q, fail_q;
  logic             cu_meta_q, cu_s_q;
  logic             he_kick;
  logic             enter;
  logic [7:0]       down_sat;

  always_ff @(posedge init_clk) begin
    if (RST) begin
      cu_meta_q <= 1'b0;
      cu_s_q    <= 1'b0;
    end else begin
      cu_meta_q <= channel_up;
      cu_s_q    <= cu_meta_q;
    end
  end

`ifdef AURORA_SUP_HARD_ERR_EN
  logic he_meta_q, he_s_q;

  always_ff @(posedge init_clk) begin
    if (RST) begin
      he_meta_q <= 1'b0;
      he_s_q    <= 1'b0;
    end else begin
      he_meta_q <= hard_err;
      he_s_q    <= he_meta_q;
    end
  end

  assign he_kick = he_s_q &&
    (state_q == S_STABLE || state_q == S_UP);
`else
  logic unused_hard_err;
  assign unused_hard_err = hard_err;
  assign he_kick = 1'b0;
`endif

  assign down_sat = (down_q == 8'hFF) ? down_q
                                      : down_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    down_d  = down_q;
    enter   = 1'b0;
    if (retrain) begin
      if (state_q == S_UP) down_d = down_sat;
      state_d = S_GT_RST;
      retry_d = 4'd0;
      enter   = 1'b1;
    end else if (he_kick) begin
      if (state_q == S_UP) down_d = down_sat;
      state_d = S_GT_RST;
      enter   = 1'b1;
    end else begin
      unique case (state_q)
        S_GT_RST: begin
          if (cnt_q == GT_LAST) begin
            state_d = S_CORE_RST;
            enter   = 1'b1;
          end
        end
        S_CORE_RST: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_UP;
            enter   = 1'b1;
          end
        end
        S_WAIT_UP: begin
          if (cu_s_q) begin
            state_d = S_STABLE;
            enter   = 1'b1;
          end else if (cnt_q == UP_LAST) begin
            enter = 1'b1;
            if (CNT_W'(retry_q) == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = S_GT_RST;
            end
          end
        end
        S_STABLE: begin
          // A drop wins over a coincident count completion.
          if (!cu_s_q) begin
            state_d = S_WAIT_UP;
            enter   = 1'b1;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_UP;
            retry_d = 4'd0;
            enter   = 1'b1;
          end
        end
        S_UP: begin
          if (!cu_s_q) begin
            down_d  = down_sat;
            state_d = S_GT_RST;
            enter   = 1'b1;
          end
        end
        S_FAIL: begin
        end
        default: begin
          state_d = S_GT_RST;
          enter   = 1'b1;
        end
      endcase
    end
    // Untimed states park the counter so it never wraps.
    if (enter || state_q == S_UP || state_q == S_FAIL)
      cnt_d = '0;
  end

  always_ff @(posedge init_clk) begin
    if (RST) begin
      state_q   <= S_GT_RST;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      down_q    <= 8'd0;
      rst_aur_q <= 1'b1;
      gt_rst_q  <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      down_q    <= down_d;
      rst_aur_q <= state_d == S_GT_RST ||
                   state_d == S_CORE_RST ||
                   state_d == S_FAIL;
      gt_rst_q  <= state_d == S_GT_RST ||
                   state_d == S_FAIL;
      ready_q   <= state_d == S_UP;
      fail_q    <= state_d == S_FAIL;
    end
  end

  assign reset_Aurora = rst_aur_q;
  assign gt_reset     = gt_rst_q;
  assign link_ready   = ready_q;
  assign link_fail    = fail_q;
  assign state_o      = state_q;
  assign retry_cnt    = retry_q;
  assign down_cnt     = down_q;

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Bench for aurora_link_supervisor: cycle model plus directed
// scenarios with hand-computed timing checks.

module tb_aurora_link_supervisor;

  localparam int GT_N  = 4;
  localparam int HLD_N = 2;
  localparam int TO_N  = 20;
  localparam int STB_N = 3;
  localparam int MR    = 2;

  localparam int GT = 0, CORE = 1, WAITU = 2;
  localparam int STB = 3, UPS = 4, FL = 5;

  logic       clk = 1'b0;
  logic       RST, channel_up, hard_err, retrain;
  logic       reset_Aurora, gt_reset;
  logic       link_ready, link_fail;
  logic [2:0] state_o;
  logic [3:0] retry_cnt;
  logic [7:0] down_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aurora_link_supervisor #(
    .GT_RESET_CYCLES  (GT_N),
    .RESET_HOLD_CYCLES(HLD_N),
    .UP_TIMEOUT_CYCLES(TO_N),
    .STABLE_CYCLES    (STB_N),
    .MAX_RETRIES      (MR),
    .CNT_W            (20)
  ) dut (
    .init_clk    (clk),
    .RST         (RST),
    .channel_up  (channel_up),
    .hard_err    (hard_err),
    .retrain     (retrain),
    .reset_Aurora(reset_Aurora),
    .gt_reset    (gt_reset),
    .link_ready  (link_ready),
    .link_fail   (link_fail),
    .state_o     (state_o),
    .retry_cnt   (retry_cnt),
    .down_cnt    (down_cnt)
  );

  // Model: state name, time spent in it, and a 2-deep input delay
  // standing in for the synchronisers.
  int m_st = GT, m_t = 0, m_retry = 0, m_down = 0;
  bit m_valid = 0;
  bit cu_h[2] = '{0, 0};
  bit he_h[2] = '{0, 0};

  always @(posedge clk) begin
    bit cu_s, he_s, moved, he_go;
    int nxt;
    cu_s = cu_h[1];
    he_s = he_h[1];
    cu_h[1] = cu_h[0]; cu_h[0] = channel_up;
    he_h[1] = he_h[0]; he_h[0] = hard_err;
    if (RST) begin
      m_st = GT; m_t = 0; m_retry = 0; m_down = 0;
      cu_h = '{0, 0}; he_h = '{0, 0};
      m_valid = 1;
    end else begin
      nxt = m_st;
      moved = 0;
`ifdef AURORA_SUP_HARD_ERR_EN
      he_go = he_s && (m_st == STB || m_st == UPS);
`else
      he_go = 0;
`endif
      if (retrain || he_go) begin
        if (m_st == UPS && m_down < 255) m_down++;
        if (retrain) m_retry = 0;
        nxt = GT; moved = 1;
      end else if (m_st == GT && m_t + 1 == GT_N) begin
        nxt = CORE; moved = 1;
      end else if (m_st == CORE && m_t + 1 == HLD_N) begin
        nxt = WAITU; moved = 1;
      end else if (m_st == WAITU && cu_s) begin
        nxt = STB; moved = 1;
      end else if (m_st == WAITU && m_t + 1 == TO_N) begin
        moved = 1;
        if (m_retry == MR) nxt = FL;
        else begin m_retry++; nxt = GT; end
      end else if (m_st == STB && !cu_s) begin
        nxt = WAITU; moved = 1;
      end else if (m_st == STB && m_t + 1 == STB_N) begin
        nxt = UPS; m_retry = 0; moved = 1;
      end else if (m_st == UPS && !cu_s) begin
        if (m_down < 255) m_down++;
        nxt = GT; moved = 1;
      end
      m_st = nxt;
      m_t = moved ? 0 : m_t + 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0]  es;
    logic [3:0]  er;
    logic [7:0]  ed;
    logic [18:0] exp_v, act_v;
    if (m_valid) begin
      es = m_st[2:0];
      er = m_retry[3:0];
      ed = m_down[7:0];
      exp_v = {es,
               1'(m_st == GT || m_st == CORE || m_st == FL),
               1'(m_st == GT || m_st == FL),
               1'(m_st == UPS), 1'(m_st == FL), er, ed};
      act_v = {state_o, reset_Aurora, gt_reset,
               link_ready, link_fail, retry_cnt, down_cnt};
      n_vec++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got %h want %h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_st(input int s, input int lim,
                         input string nm);
    int n;
    logic [2:0] w;
    w = s[2:0];
    n = 0;
    while (state_o !== w && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {29'd0, state_o}, s);
  endtask

  task automatic pulse_rst();
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic pulse_retrain();
    retrain = 1'b1;
    @(negedge clk);
    retrain = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r, s, n, c;
    bit saw_stb, saw_rdy;
    RST = 1'b1; channel_up = 1'b1;
    hard_err = 1'b0; retrain = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, state_o}, 0);
    chk("rst_resets", {30'd0, reset_Aurora, gt_reset}, 3);
    chk("rst_flags", {30'd0, link_ready, link_fail}, 0);
    chk("rst_cnts", {20'd0, retry_cnt, down_cnt}, 0);

    // 1: bring-up with channel_up already high
    RST = 1'b0;
    g = 0; r = 0; s = 0;
    for (int i = 0; i < 40 && !link_ready; i++) begin
      if (gt_reset) g++;
      if (reset_Aurora) r++;
      if (state_o == 3'd3) s++;
      @(negedge clk);
    end
    chk("gt_reset_len", g, 4);
    chk("reset_len", r, 6);
    chk("stable_len", s, 3);
    chk("up_ready", {31'd0, link_ready}, 1);
    chk("up_retry", {28'd0, retry_cnt}, 0);

    // 2: no channel_up -> two retries then FAIL
    channel_up = 1'b0;
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    n = 0;
    while (!link_fail && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 30) chk("retry_1", {28'd0, retry_cnt}, 1);
      if (n == 56) chk("retry_2", {28'd0, retry_cnt}, 2);
    end
    chk("fail_time", n, 78);
    chk("fail_state", {29'd0, state_o}, 5);
    chk("fail_resets", {30'd0, reset_Aurora, gt_reset}, 3);
    chk("fail_retry", {28'd0, retry_cnt}, 2);
    repeat (5) @(negedge clk);
    chk("fail_hold", {31'd0, link_fail}, 1);
    pulse_retrain();
    chk("retrain_state", {29'd0, state_o}, 0);
    chk("retrain_retry", {28'd0, retry_cnt}, 0);
    chk("retrain_fail", {31'd0, link_fail}, 0);

    // 3: two-cycle channel_up glitch in WAIT_UP
    wait_st(WAITU, 20, "to_wait");
    channel_up = 1'b1;
    repeat (2) @(negedge clk);
    channel_up = 1'b0;
    saw_stb = 0; saw_rdy = 0;
    repeat (8) begin
      @(negedge clk);
      if (state_o == 3'd3) saw_stb = 1;
      if (link_ready) saw_rdy = 1;
    end
    chk("glitch_stable", {31'd0, saw_stb}, 1);
    chk("glitch_ready", {31'd0, saw_rdy}, 0);
    chk("glitch_back", {29'd0, state_o}, 2);
    chk("glitch_retry", {28'd0, retry_cnt}, 0);

    // 4: repeated one-cycle losses from UP
    channel_up = 1'b1;
    wait_st(UPS, 60, "to_up");
    for (int k = 0; k < 300; k++) begin
      channel_up = 1'b0;
      @(negedge clk);
      channel_up = 1'b1;
      c = 1;
      while (state_o != 3'd0 && c < 10) begin
        @(negedge clk);
        c++;
      end
      if (k == 0) begin
        chk("loss_latency", c, 3);
        chk("loss_ready", {31'd0, link_ready}, 0);
        chk("loss_down", {24'd0, down_cnt}, 1);
      end
      wait_st(UPS, 40, "reup");
    end
    chk("down_sat", {24'd0, down_cnt}, 255);

    // 5: RST in CORE_RST and in UP
    pulse_retrain();
    chk("retrain_up_sat", {24'd0, down_cnt}, 255);
    wait_st(CORE, 10, "to_core");
    pulse_rst();
    chk("rc_state", {29'd0, state_o}, 0);
    chk("rc_resets", {30'd0, reset_Aurora, gt_reset}, 3);
    chk("rc_cnts", {20'd0, retry_cnt, down_cnt}, 0);
    wait_st(UPS, 40, "up_after_rc");
    pulse_retrain();
    chk("retrain_down", {24'd0, down_cnt}, 1);
    chk("retrain_gt", {29'd0, state_o}, 0);
    wait_st(UPS, 40, "up_again");
    pulse_rst();
    chk("ru_state", {29'd0, state_o}, 0);
    chk("ru_ready", {31'd0, link_ready}, 0);
    chk("ru_cnts", {20'd0, retry_cnt, down_cnt}, 0);
    chk("ru_resets", {30'd0, reset_Aurora, gt_reset}, 3);
    wait_st(UPS, 40, "up_final");

    // 6: hard_err pulse in UP
    hard_err = 1'b1;
    @(negedge clk);
    hard_err = 1'b0;
    repeat (2) @(negedge clk);
`ifdef AURORA_SUP_HARD_ERR_EN
    chk("he_state", {29'd0, state_o}, 0);
    chk("he_down", {24'd0, down_cnt}, 1);
`else
    repeat (4) @(negedge clk);
    chk("he_state", {29'd0, state_o}, 4);
    chk("he_down", {24'd0, down_cnt}, 0);
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
